// File: rtl/mfp_ahb_ram_slave.sv
// AHB-lite RAM responder: byte/half/word writes, word reads, optional wait states,
// two-cycle ERROR response on illegal size/alignment, read-after-write forwarding.
module mfp_ahb_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned WordAw   = ADDR_WIDTH - 2;
    localparam int unsigned Depth    = 2 ** WordAw;
    localparam logic [2:0]  WaitLoad = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StErr1,
        StErr2
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    dp_valid_q, dp_valid_d;
    logic                    dp_write_q, dp_write_d;
    logic [2:0]              dp_size_q, dp_size_d;
    logic [ADDR_WIDTH-1:0]   dp_addr_q, dp_addr_d;
    logic [31:0]             rdata_q, rdata_d;

    logic [31:0]             mem [Depth];

    logic                    ready;
    logic                    accept;
    logic                    legal;
    logic                    wr_commit;
    logic [3:0]              wr_mask;
    logic [31:0]             rd_word;
    logic                    fwd_hit;
    logic                    unused_inputs;

    assign unused_inputs = ^{HBURST, HADDR[31:ADDR_WIDTH], HTRANS[0]};

    assign ready     = (state_q == StIdle) || (state_q == StErr2);
    assign HREADYOUT = ready;
    assign HRESP     = (state_q == StErr1) || (state_q == StErr2);
    assign HRDATA    = rdata_q;

    // ready also gates acceptance so a mis-driven HREADY cannot disturb a stalled data phase
    assign accept = HSEL & HREADY & HTRANS[1] & ready;

    always_comb begin
        legal = 1'b0;
        case (HSIZE)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~HADDR[0];
            3'd2:    legal = (HADDR[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        wr_mask = 4'b0000;
        case (dp_size_q)
            3'd0:    wr_mask = 4'b0001 << dp_addr_q[1:0];
            3'd1:    wr_mask = dp_addr_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    wr_mask = 4'b1111;
            default: wr_mask = 4'b0000;
        endcase
    end

    assign wr_commit = dp_valid_q & dp_write_q & ready;
    assign fwd_hit   = wr_commit && (dp_addr_q[ADDR_WIDTH-1:2] == HADDR[ADDR_WIDTH-1:2]);

    // Merge the bytes committing this cycle so a back-to-back read sees them without a stall
    always_comb begin
        rd_word = mem[HADDR[ADDR_WIDTH-1:2]];
        if (fwd_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    rd_word[8*i +: 8] = HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_size_d  = dp_size_q;
        dp_addr_d  = dp_addr_q;
        rdata_d    = rdata_q;

        if (dp_valid_q && ready) begin
            dp_valid_d = 1'b0;
        end

        unique case (state_q)
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = StIdle;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            dp_addr_d  = HADDR[ADDR_WIDTH-1:0];
            dp_size_d  = HSIZE;
            dp_write_d = HWRITE;
            if (legal) begin
                dp_valid_d = 1'b1;
                if (!HWRITE) begin
                    rdata_d = rd_word;
                end
                if (WAIT_STATES != 0) begin
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                end else begin
                    state_d = StIdle;
                end
            end else begin
                dp_valid_d = 1'b0;
                state_d    = StErr1;
                rdata_d    = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_size_q  <= 3'd0;
            dp_addr_q  <= '0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_size_q  <= dp_size_d;
            dp_addr_q  <= dp_addr_d;
            rdata_q    <= rdata_d;
        end
    end

    // RAM is not reset; dp_valid_q clears asynchronously, so a reset drops any pending write
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[dp_addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/mfp_ahb_ram_slave.md
Name: mfp_ahb_ram_slave

Overview:
- AHB-lite responder: a single-port on-chip RAM that accepts the transfers produced by the UART program loader and the CPU bus matrix.
- Supports byte, halfword and word writes on the correct byte lanes, and word reads.
- Has a parameterised number of wait states and returns a two-cycle ERROR response on illegal transfers.
- Sits behind the AHB-lite decoder/mux as one slave, so loaded program images can be read back by the core.

Parameters:
- ADDR_WIDTH, 14, byte-address bits decoded; memory depth is 2^(ADDR_WIDTH-2) 32-bit words.
- WAIT_STATES, 0, extra data-phase cycles (HREADYOUT low) inserted per accepted transfer; legal range 0..7.

Ports:
- HCLK  input  1  single clock; all state updates on rising edge.
- HRESETn  input  1  reset, asynchronous assert, active-low.
- HSEL  input  1  slave select from decoder.
- HADDR  input  32  byte address; bits [ADDR_WIDTH-1:0] used, upper bits ignored.
- HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ.
- HSIZE  input  3  0=byte, 1=halfword, 2=word, others illegal.
- HBURST  input  3  ignored; every beat is handled as an independent transfer.
- HWRITE  input  1  1=write.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  bus-level ready (mux output).
- HRDATA  output  32  read data.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending-write flag cleared. RAM contents are undefined and are not cleared.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register HADDR[ADDR_WIDTH-1:0], HSIZE and HWRITE.
- IDLE/BUSY transfers, or HSEL=0: no access, OKAY, zero wait.
- Legality check at acceptance:
  - HSIZE>2 is illegal.
  - Halfword with HADDR[0]=1 is illegal.
  - Word with HADDR[1:0]!=0 is illegal.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on a legal accept with WAIT_STATES=0, stay IDLE and the data phase completes next cycle with HREADYOUT=1. With WAIT_STATES>0, go to WAIT and load the counter with WAIT_STATES.
  - WAIT: HREADYOUT=0 and the counter decrements each cycle. At 1, go to IDLE; HREADYOUT=1 in the following cycle.
  - Illegal accept goes to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1. Next state is ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new address phase may be accepted in this cycle. Next state is IDLE, or ERR1/WAIT per that new accept.
  - An errored transfer never writes RAM.
- Write: the byte mask is derived from the registered size and address.
  - Byte: lane = addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all lanes.
  - HWDATA is taken from the same lanes, matching the loader's shifted-byte HWDATA.
  - The RAM write commits on the clock edge at which the data phase completes (HREADYOUT=1).
- Read: returns the full 32-bit word at addr[ADDR_WIDTH-1:2], regardless of size. HRDATA is valid in the cycle HREADYOUT=1 ends the data phase. Read latency is 1+WAIT_STATES cycles after the address phase.
- Read-after-write forwarding: a read address phase coinciding with a write data phase to the same word must return the merged (new) bytes. No stall is allowed for this case.
- Address wrap: addresses at or above 2^ADDR_WIDTH alias modulo the memory size.
- HRDATA holds its last value outside read data phases. It is don't-care in ERR states, but the implementation drives 0.
- Reset mid-operation (WAIT or ERR1):
  - Outputs return to reset values immediately.
  - The pending write is discarded.
  - No partial RAM update occurs.

Test Plan:
- Loader pattern: 4 byte writes to 0x100..0x103 with HWDATA=0x00000011, 0x00002200, 0x00330000, 0x44000000, then a word read at 0x100 → HRDATA=0x44332211, OKAY, zero wait.
- Back-to-back: word write 0xDEADBEEF to 0x40, then in the next address phase a read of 0x40 → HRDATA=0xDEADBEEF. Then a halfword write 0x1234 to 0x42 and an immediate read → 0x1234BEEF.
- Illegal: halfword write at 0x201 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). A word read of 0x200 is unchanged; HSIZE=3 gives the same error sequence.
- WAIT_STATES=2: read at 0x10 → HREADYOUT low for exactly 2 cycles, data valid in the 3rd data-phase cycle. A pipelined next address phase is accepted only with HREADY=1.
- IDLE/BUSY with HSEL=1, and any transfer with HSEL=0 → HREADYOUT=1, HRESP=0, no RAM change.
- ADDR_WIDTH=14: write 0xA5 byte at 0x4004, read 0x0004 → lane 0 = 0xA5 (alias). Assert HRESETn low during WAIT → HREADYOUT=1, HRESP=0 the same cycle, and the pending write is lost.
